// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and requester indices for the write-back port arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package wb_port_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;

  // Bit positions in the two-entry valid/grant vectors.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Two-way grant picker; round-robin when WB_ARB_RR_EN is defined, else MEM-wins fixed priority.
// Latency: grants are combinational from valids (and the pointer flop in RR mode).
// Backpressure: the loser of a conflict sees grant low until it wins; a grant is never dropped while its valid holds.
module rr_pick2
  import wb_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       xfer,
  output logic [1:0] grant
);

  logic contested;
  assign contested = valid[REQ_ALU] & valid[REQ_MEM];

`ifdef WB_ARB_RR_EN
  // ptr = 0 favours the ALU path, ptr = 1 favours the memory path.
  logic ptr;

  // Uncontested: pass the lone valid through. Contested: pointer decides.
  always_comb begin
    grant = valid;
    if (contested) begin
      grant[REQ_ALU] = ~ptr;
      grant[REQ_MEM] = ptr;
    end
  end

  // Hand priority to the other side after each contested transfer only, so a
  // held valid never loses its grant mid-wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (xfer && contested) begin
      ptr <= grant[REQ_ALU];
    end
  end
`else
  // Load path always wins a conflict; no state is needed.
  always_comb begin
    grant = valid;
    if (contested) begin
      grant[REQ_ALU] = 1'b0;
    end
  end

  // Clock, reset and strobe have no consumer in the fixed-priority build.
  logic unused_fixed;
  assign unused_fixed = &{1'b0, clk, rst, xfer};
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the ALU and load return paths; counts conflicts.
// Latency: ready is combinational; wr_en/wr_addr/wr_data follow one cycle after the handshake.
// Backpressure: one requester granted per cycle; the loser holds valid until granted. Build option WB_ARB_RR_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [1:0]        valid;
  logic [1:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign valid[REQ_ALU] = req0_valid;
  assign valid[REQ_MEM] = req1_valid;

  rr_pick2 u_pick (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .xfer  (xfer),
    .grant (grant)
  );

  assign req0_ready = grant[REQ_ALU];
  assign req1_ready = grant[REQ_MEM];
  assign xfer       = |(valid & grant);

  assign sel_addr = grant[REQ_MEM] ? req1_addr : req0_addr;
  assign sel_data = grant[REQ_MEM] ? req1_data : req0_data;

  // Output stage: capture the winner; writes to x0 are consumed without a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (xfer) begin
      wr_en   <= (sel_addr != '0);
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Saturating count of cycles where both requesters competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (req0_valid && req1_valid && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; expectations follow the WB_ARB_RR_EN build option.
// Latency: checks ready #1 after driving, registered outputs #1 after the edge.
// Backpressure: requesters hold valid until granted.
module tb_wb_port_arbiter;

`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] conflict_cnt;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", conflict_cnt); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready}); end
    tick();
    idle_inputs();
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b expected 1", wr_en); end
    checks++; if (wr_addr !== 5'd5) begin errors++; $display("FAIL single_wr_addr: got %h expected 05", wr_addr); end
    checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wr_data: got %h expected deadbeef", wr_data); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_wr_en_drop: got %b expected 0", wr_en); end
    checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold_data: got %h expected deadbeef", wr_data); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL single_cnt: got %h expected 0", conflict_cnt); end
  endtask

  task automatic test_contend();
    logic       exp_g0;
    logic [4:0] exp_addr;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_0011;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_0022;
    for (int k = 0; k < 4; k++) begin
      exp_g0   = RR && (k % 2 == 0);
      exp_addr = exp_g0 ? 5'd1 : 5'd2;
      #1;
      checks++; if ({req0_ready, req1_ready} !== {exp_g0, ~exp_g0}) begin errors++; $display("FAIL contend_ready[%0d]: got %b expected %b", k, {req0_ready, req1_ready}, {exp_g0, ~exp_g0}); end
      tick();
      checks++; if (wr_addr !== exp_addr || wr_en !== 1'b1) begin errors++; $display("FAIL contend_wr[%0d]: got en=%b addr=%h expected en=1 addr=%h", k, wr_en, wr_addr, exp_addr); end
    end
    idle_inputs();
    checks++; if (conflict_cnt !== 16'd4) begin errors++; $display("FAIL contend_cnt: got %0d expected 4", conflict_cnt); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL contend_idle_en: got %b expected 0", wr_en); end
  endtask

  task automatic test_x0();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL x0_ready: got %b expected 01", {req0_ready, req1_ready}); end
    tick();
    idle_inputs();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL x0_wr_en: got %b expected 0", wr_en); end
    checks++; if (wr_data !== 32'h0000_1234) begin errors++; $display("FAIL x0_wr_data: got %h expected 00001234", wr_data); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL x0_wr_en_after: got %b expected 0", wr_en); end
  endtask

  task automatic test_saturate();
    // Counter is at 4 from the contention test.
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_0011;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_0022;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 16'd14) begin errors++; $display("FAIL sat_mid: got %0d expected 14", conflict_cnt); end
    repeat ((1 << 16) + 3 - 10) @(posedge clk);
    #1;
    idle_inputs();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", conflict_cnt); end
    tick();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_idle: got %h expected ffff", conflict_cnt); end
  endtask

  task automatic test_async_reset();
    logic       exp_g0;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA5A5_A5A5;
    tick();
    idle_inputs();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7) begin errors++; $display("FAIL areset_pre: got en=%b addr=%h expected en=1 addr=07", wr_en, wr_addr); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL areset_wr_en: got %b expected 0", wr_en); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL areset_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL areset_wr_data: got %h expected 0", wr_data); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL areset_cnt: got %h expected 0", conflict_cnt); end
    #1;
    rst = 1'b0;
    tick();
    exp_g0 = RR;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0033;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_0044;
    #1;
    checks++; if ({req0_ready, req1_ready} !== {exp_g0, ~exp_g0}) begin errors++; $display("FAIL areset_first_grant: got %b expected %b", {req0_ready, req1_ready}, {exp_g0, ~exp_g0}); end
    tick();
    idle_inputs();
    checks++; if (wr_addr !== (exp_g0 ? 5'd3 : 5'd4)) begin errors++; $display("FAIL areset_first_addr: got %h expected %h", wr_addr, exp_g0 ? 5'd3 : 5'd4); end
    checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL areset_cnt_restart: got %0d expected 1", conflict_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contend();
    test_x0();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
